// File: rtl/press_classifier.sv
// Button press classifier: turns a debounced button level into press/release
// edges and short-click, double-click, long-press and auto-repeat events.
module press_classifier #(
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES    = 30_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn_level,
    input  logic i_enable,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_short_click,
    output logic o_double_click,
    output logic o_long_press,
    output logic o_repeat_pulse,
    output logic o_held
);

    localparam int MAX_A  = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int MAX_P  = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CW     = $clog2(MAX_P) + 1;

    // The counter holds (edges since state entry) - 1 before the deciding edge.
    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_GAP,
        SECOND_HELD
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_nextCnt;
    logic            r_prevLevel;

    logic w_press;
    logic w_release;
    logic w_short;
    logic w_double;
    logic w_long;
    logic w_repeat;
    logic w_held;

    logic w_pressEdge;
    logic w_releaseEdge;

    assign w_pressEdge   = i_btn_level & ~r_prevLevel;
    assign w_releaseEdge = ~i_btn_level & r_prevLevel;

    // State, counter, previous sample and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_prevLevel     <= 1'b1;
            o_press_pulse   <= 1'b0;
            o_release_pulse <= 1'b0;
            o_short_click   <= 1'b0;
            o_double_click  <= 1'b0;
            o_long_press    <= 1'b0;
            o_repeat_pulse  <= 1'b0;
            o_held          <= 1'b0;
        end else begin
            r_state         <= w_nextState;
            r_cnt           <= w_nextCnt;
            r_prevLevel     <= i_btn_level;
            o_press_pulse   <= w_press;
            o_release_pulse <= w_release;
            o_short_click   <= w_short;
            o_double_click  <= w_double;
            o_long_press    <= w_long;
            o_repeat_pulse  <= w_repeat;
            o_held          <= w_held;
        end
    end

    // Next-state, counter and event decisions; gap expiry beats a coincident press.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt + 1'b1;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_short     = 1'b0;
        w_double    = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        w_held      = 1'b0;

        case (r_state)
            IDLE: begin
                w_nextCnt = '0;
                if (w_pressEdge) begin
                    w_press     = 1'b1;
                    w_nextState = PRESSED;
                end
            end
            PRESSED: begin
                if (w_releaseEdge) begin
                    w_release   = 1'b1;
                    w_nextState = WAIT_GAP;
                    w_nextCnt   = '0;
                end else if (i_btn_level && r_cnt == LONG_LAST) begin
                    w_long      = 1'b1;
                    w_nextState = LONG_HELD;
                    w_nextCnt   = '0;
                end
            end
            LONG_HELD: begin
                if (w_releaseEdge) begin
                    w_release   = 1'b1;
                    w_nextState = IDLE;
                    w_nextCnt   = '0;
                end else if (r_cnt == REPEAT_LAST) begin
                    w_repeat  = 1'b1;
                    w_nextCnt = '0;
                end
            end
            WAIT_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_short   = 1'b1;
                    w_nextCnt = '0;
                    if (w_pressEdge) begin
                        w_press     = 1'b1;
                        w_nextState = PRESSED;
                    end else begin
                        w_nextState = IDLE;
                    end
                end else if (w_pressEdge) begin
                    w_press     = 1'b1;
                    w_double    = 1'b1;
                    w_nextState = SECOND_HELD;
                    w_nextCnt   = '0;
                end
            end
            SECOND_HELD: begin
                w_nextCnt = r_cnt;
                if (w_releaseEdge) begin
                    w_release   = 1'b1;
                    w_nextState = IDLE;
                    w_nextCnt   = '0;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = '0;
            end
        endcase

        if (!i_enable) begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
            w_press     = 1'b0;
            w_release   = 1'b0;
            w_short     = 1'b0;
            w_double    = 1'b0;
            w_long      = 1'b0;
            w_repeat    = 1'b0;
        end

        w_held = (w_nextState == PRESSED) || (w_nextState == LONG_HELD) ||
                 (w_nextState == SECOND_HELD);
    end

endmodule

// File: doc/press_classifier.md
PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 SHALL provide parameter LONG_CYCLES, default 100_000_000, hold time in clk cycles that qualifies a long press.
REQ-002 SHALL provide parameter REPEAT_CYCLES, default 25_000_000, auto-repeat period in clk cycles while a long press is held.
REQ-003 SHALL provide parameter GAP_CYCLES, default 30_000_000, maximum release-to-press gap in clk cycles that qualifies a double click.
REQ-004 SHALL accept only parameter values >= 2; counter width is $clog2 of the largest parameter plus 1.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 btn_level  input  1  debounced button level, synchronous to clk, 1 = pressed.
REQ-008 enable  input  1  1 = classify; 0 = block idle.
REQ-009 press_pulse  output  1  one-cycle pulse on each accepted press edge.
REQ-010 release_pulse  output  1  one-cycle pulse on each accepted release edge.
REQ-011 short_click  output  1  one-cycle pulse for a single short press.
REQ-012 double_click  output  1  one-cycle pulse for a second press within the gap window.
REQ-013 long_press  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
REQ-014 repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while long-held.
REQ-015 held  output  1  level; 1 while the FSM is in PRESSED, LONG_HELD or SECOND_HELD.

Function
REQ-016 SHALL register every output; an event decided at clk edge k SHALL be visible for exactly the cycle following edge k.
REQ-017 SHALL detect edges against a 1-bit previous-sample register; a press edge is sampled 1 with previous 0, a release edge is sampled 0 with previous 1.
REQ-018 SHALL implement FSM states IDLE, PRESSED, LONG_HELD, WAIT_GAP, SECOND_HELD, with a single shared cycle counter cleared on every state entry.
REQ-019 IDLE: press edge -> PRESSED, press_pulse.
REQ-020 PRESSED: counter increments each edge; when btn_level is still 1 at edge LONG_CYCLES (press edge = edge 0) -> long_press, LONG_HELD; a release edge before that -> release_pulse, WAIT_GAP.
REQ-021 LONG_HELD: repeat_pulse at edges LONG_CYCLES + n*REPEAT_CYCLES, n >= 1; release edge -> release_pulse, IDLE; no short_click or double_click for this press.
REQ-022 WAIT_GAP (release at edge r): press edge at edge s with r < s < r+GAP_CYCLES -> press_pulse, double_click, SECOND_HELD; no press by edge r+GAP_CYCLES -> short_click, IDLE.
REQ-023 Gap boundary: press edge exactly at edge r+GAP_CYCLES -> short_click and press_pulse in the same cycle, next state PRESSED (expiry has precedence, press treated as a new first press).
REQ-024 SECOND_HELD: no long_press or repeat regardless of duration; release edge -> release_pulse, IDLE.
REQ-025 At most one of short_click, double_click, long_press SHALL assert per press sequence.
REQ-026 enable=0 SHALL force IDLE, clear the counter and hold all outputs at 0; the previous-sample register keeps tracking btn_level, so no edge is fabricated when enable returns to 1.

Reset
REQ-027 reset=1 SHALL force state IDLE, counter 0, all outputs 0, and previous-sample register 1.
REQ-028 A button held high through reset release SHALL produce no press_pulse or classification until it has been sampled 0 and then 1.
REQ-029 reset mid-sequence (any state) SHALL discard the pending classification with no pulse emitted.

Verification (LONG_CYCLES=20, REPEAT_CYCLES=5, GAP_CYCLES=8)
REQ-030 Short click: btn high 5 cycles, then low -> press_pulse after edge 0, release_pulse after edge 5, short_click after edge 13; no other pulses.
REQ-031 Long hold: btn high 32 cycles -> long_press after edge 20, repeat_pulse after edges 25 and 30, release_pulse on release; held=1 throughout; no short_click.
REQ-032 Double click: high 3, low 4, high 3, low -> two press_pulses, double_click coincident with the second press_pulse, no short_click; return to IDLE after the second release.
REQ-033 Gap boundary: release at edge r, press exactly at edge r+8 -> short_click and press_pulse in the same cycle; a further 20-cycle hold then yields long_press.
REQ-034 Reset with btn high: assert reset during LONG_HELD and hold btn high after release of reset -> all outputs 0, no press_pulse; btn low then high -> press_pulse.
REQ-035 Enable drop: enable=0 at cycle 10 of a press, restored while btn still high -> no long_press, no pulses; next genuine press edge classifies normally.
